// File: rtl/loadq_sched_pkg.sv
// ----------------------------------------------------------------------------
// loadq_sched_pkg
// Shared load-queue definitions for the default 8-entry configuration.
//   LDQ_NUM_ENTRIES : number of load queue entries (power of two, >= 2)
//   LDQ_ID_W        : entry index width
//   t_ldq_id        : entry index
//   t_ldq_ptr       : circular pointer, wrap bit above the entry index
// ----------------------------------------------------------------------------
package loadq_sched_pkg;

    localparam int LDQ_NUM_ENTRIES = 8;
    localparam int LDQ_ID_W        = $clog2(LDQ_NUM_ENTRIES);

    typedef logic [LDQ_ID_W-1:0] t_ldq_id;

    typedef struct packed {
        logic    wrap;
        t_ldq_id idx;
    } t_ldq_ptr;

endpackage

// File: rtl/loadq_sched_if.sv
// ----------------------------------------------------------------------------
// loadq_sched_if
// Alloc-stage and mem-pipe handshake bundle of the load queue scheduler.
//   alloc_req_rs0      : alloc stage asks for one entry
//   alloc_gnt_rs0      : request accepted this cycle
//   alloc_id_rs0       : allocated entry index (valid with alloc_gnt_rs0)
//   pipe_stall_mm0     : mem pipe cannot take a load this cycle
//   pipe_gnt_valid_mm0 : a load was granted the pipe
//   pipe_gnt_id_mm0    : granted entry index
// master = alloc stage / mem pipe side, slave = scheduler.
// ----------------------------------------------------------------------------
interface loadq_sched_if #(
    parameter int LDQ_ID_W = loadq_sched_pkg::LDQ_ID_W
);
    import loadq_sched_pkg::*;

    logic                alloc_req_rs0;
    logic                alloc_gnt_rs0;
    logic [LDQ_ID_W-1:0] alloc_id_rs0;
    logic                pipe_stall_mm0;
    logic                pipe_gnt_valid_mm0;
    logic [LDQ_ID_W-1:0] pipe_gnt_id_mm0;

    modport master (
        output alloc_req_rs0,
        output pipe_stall_mm0,
        input  alloc_gnt_rs0,
        input  alloc_id_rs0,
        input  pipe_gnt_valid_mm0,
        input  pipe_gnt_id_mm0
    );

    modport slave (
        input  alloc_req_rs0,
        input  pipe_stall_mm0,
        output alloc_gnt_rs0,
        output alloc_id_rs0,
        output pipe_gnt_valid_mm0,
        output pipe_gnt_id_mm0
    );

endinterface

// File: rtl/loadq_sched_oldest_first_pick.sv
// ----------------------------------------------------------------------------
// oldest_first_pick
// Picks the first set request at or after base_i, walking upward with
// wrap-around. With base_i = queue head this is the oldest requester.
//   req_i  : request vector
//   base_i : index treated as the oldest position
//   gnt_o  : one-hot grant (zero when no request)
//   idx_o  : granted index (zero when no request)
//   vld_o  : any request present
// ----------------------------------------------------------------------------
module oldest_first_pick #(
    parameter int N  = 8,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] base_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          vld_o
);
    import loadq_sched_pkg::*;

    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    logic [IW-1:0]  off;

    always_comb begin
        // Rotating right by base puts the oldest slot at bit 0.
        dbl   = {req_i, req_i} >> base_i;
        rot   = dbl[N-1:0];
        vld_o = |rot;
        off   = '0;
        // Descending scan: the last hit is the lowest set bit.
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) off = IW'(k);
        end
        // N is a power of two, so the IW-bit add wraps back modulo N.
        idx_o = vld_o ? IW'(off + base_i) : '0;
        gnt_o = vld_o ? ({{(N-1){1'b0}}, 1'b1} << idx_o) : '0;
    end

endmodule

// File: rtl/loadq_sched.sv
// ----------------------------------------------------------------------------
// loadq_sched
// Load queue controller: owns the circular head/tail pointers, allocates one
// entry per cycle at rs0, retires free entries in order from the head, and
// grants the oldest pipe requester at mm0. A nuke empties the queue by
// pulling tail back to head.
//   clk, reset_n     : clock, asynchronous active-low reset
//   bus (slave)      : alloc and mem-pipe handshake
//   e_alloc_rs0      : one-hot alloc strobe to entries
//   ldq_full         : no free entry
//   ldq_count        : occupied entries
//   e_valid          : per-entry busy
//   e_pipe_req_mm0   : per-entry pipe request
//   e_pipe_gnt_mm0   : one-hot pipe grant to entries
//   nuke_valid_rb1   : pipeline nuke
// Optional build macro LDQ_SCHED_PERF_EN adds saturating counters
//   perf_full_cycles, perf_pipe_gnts, perf_stall_req_cycles (32 bit each).
// ----------------------------------------------------------------------------
module loadq_sched #(
    parameter int LDQ_NUM_ENTRIES = loadq_sched_pkg::LDQ_NUM_ENTRIES,
    parameter int LDQ_ID_W        = $clog2(LDQ_NUM_ENTRIES)
) (
    input  logic                       clk,
    input  logic                       reset_n,
    loadq_sched_if.slave               bus,
    output logic [LDQ_NUM_ENTRIES-1:0] e_alloc_rs0,
    output logic                       ldq_full,
    output logic [LDQ_ID_W:0]          ldq_count,
    input  logic [LDQ_NUM_ENTRIES-1:0] e_valid,
    input  logic [LDQ_NUM_ENTRIES-1:0] e_pipe_req_mm0,
    output logic [LDQ_NUM_ENTRIES-1:0] e_pipe_gnt_mm0,
    input  logic                       nuke_valid_rb1
`ifdef LDQ_SCHED_PERF_EN
    ,
    output logic [31:0]                perf_full_cycles,
    output logic [31:0]                perf_pipe_gnts,
    output logic [31:0]                perf_stall_req_cycles
`endif
);
    import loadq_sched_pkg::*;

    typedef struct packed {
        logic                wrap;
        logic [LDQ_ID_W-1:0] idx;
    } t_ptr;

    localparam logic [LDQ_ID_W:0] PTR_ONE = (LDQ_ID_W+1)'(1);

    function automatic t_ptr ptr_inc(input t_ptr p);
        return t_ptr'(p + PTR_ONE);
    endfunction

    t_ptr                       head_q, head_d, tail_q, tail_d;
    logic                       empty, full, alloc_gnt, dealloc, gnt_en;
    logic [LDQ_ID_W:0]          count;
    logic [LDQ_ID_W-1:0]        off;
    logic [LDQ_NUM_ENTRIES-1:0] occ, req_m, pick_gnt;
    logic [LDQ_ID_W-1:0]        pick_idx;
    logic                       pick_vld;

    assign empty   = (head_q == tail_q);
    assign full    = (head_q.idx == tail_q.idx) && (head_q.wrap != tail_q.wrap);
    assign count   = tail_q - head_q;
    assign dealloc = ~empty & ~e_valid[head_q.idx];

    // ---- rs0: allocation from tail ----
    assign alloc_gnt         = bus.alloc_req_rs0 & ~full & ~nuke_valid_rb1;
    assign bus.alloc_gnt_rs0 = alloc_gnt;
    assign bus.alloc_id_rs0  = tail_q.idx;
    assign e_alloc_rs0       = alloc_gnt ? ({{(LDQ_NUM_ENTRIES-1){1'b0}}, 1'b1} << tail_q.idx) : '0;
    assign ldq_full          = full;
    assign ldq_count         = count;

    // Occupied slots are those whose distance from head is below count.
    always_comb begin
        occ = '0;
        off = '0;
        for (int i = 0; i < LDQ_NUM_ENTRIES; i++) begin
            off    = LDQ_ID_W'(i) - head_q.idx;
            occ[i] = ({1'b0, off} < count);
        end
    end

    // ---- mm0: oldest-first pipe arbitration ----
    assign req_m = e_pipe_req_mm0 & occ;

    oldest_first_pick #(
        .N  (LDQ_NUM_ENTRIES),
        .IW (LDQ_ID_W)
    ) u_pick (
        .req_i  (req_m),
        .base_i (head_q.idx),
        .gnt_o  (pick_gnt),
        .idx_o  (pick_idx),
        .vld_o  (pick_vld)
    );

    assign gnt_en                 = pick_vld & ~bus.pipe_stall_mm0 & ~nuke_valid_rb1;
    assign e_pipe_gnt_mm0         = gnt_en ? pick_gnt : '0;
    assign bus.pipe_gnt_valid_mm0 = gnt_en;
    assign bus.pipe_gnt_id_mm0    = gnt_en ? pick_idx : '0;

    // ---- pointer update ----
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        if (nuke_valid_rb1) begin
            // Every entry drops to idle, so the queue collapses onto head.
            tail_d = head_q;
        end else begin
            if (alloc_gnt) tail_d = ptr_inc(tail_q);
            if (dealloc)   head_d = ptr_inc(head_q);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head_q <= '0;
            tail_q <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

`ifdef LDQ_SCHED_PERF_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
        return (en && (v != '1)) ? v + 32'd1 : v;
    endfunction

    logic [31:0] perf_full_q, perf_gnt_q, perf_stall_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_full_q  <= '0;
            perf_gnt_q   <= '0;
            perf_stall_q <= '0;
        end else begin
            perf_full_q  <= sat_inc(perf_full_q, full);
            perf_gnt_q   <= sat_inc(perf_gnt_q, gnt_en);
            perf_stall_q <= sat_inc(perf_stall_q, bus.pipe_stall_mm0 & (|e_pipe_req_mm0));
        end
    end

    assign perf_full_cycles      = perf_full_q;
    assign perf_pipe_gnts        = perf_gnt_q;
    assign perf_stall_req_cycles = perf_stall_q;
`endif

    a_alloc_free: assert property (@(posedge clk) disable iff (!reset_n)
        (e_alloc_rs0 & e_valid) == '0);
    a_gnt_onehot: assert property (@(posedge clk) disable iff (!reset_n)
        $onehot0(e_pipe_gnt_mm0));
    a_gnt_req: assert property (@(posedge clk) disable iff (!reset_n)
        (e_pipe_gnt_mm0 & ~e_pipe_req_mm0) == '0);
    a_req_in_range: assert property (@(posedge clk) disable iff (!reset_n)
        (e_pipe_req_mm0 & ~occ) == '0);
    a_count_max: assert property (@(posedge clk) disable iff (!reset_n)
        ldq_count <= (LDQ_ID_W+1)'(LDQ_NUM_ENTRIES));

endmodule

// File: tb/tb_loadq_sched.sv
module tb_loadq_sched;
    import loadq_sched_pkg::*;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] e_alloc, e_pgnt, ev, req;
    logic       ldq_full, nuke;
    logic [3:0] ldq_count;
    int         errors = 0;
    int         checks = 0;
    int         mh = 0;
    int         mt = 0;
    int         alloc_q[$];
    int         gnt_q[$];

`ifdef LDQ_SCHED_PERF_EN
    logic [31:0] perf_full, perf_gnts, perf_stall;
`endif

    always #5 clk = ~clk;

    loadq_sched_if bus ();

    loadq_sched dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .bus            (bus),
        .e_alloc_rs0    (e_alloc),
        .ldq_full       (ldq_full),
        .ldq_count      (ldq_count),
        .e_valid        (ev),
        .e_pipe_req_mm0 (req),
        .e_pipe_gnt_mm0 (e_pgnt),
        .nuke_valid_rb1 (nuke)
`ifdef LDQ_SCHED_PERF_EN
        ,
        .perf_full_cycles      (perf_full),
        .perf_pipe_gnts        (perf_gnts),
        .perf_stall_req_cycles (perf_stall)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: predict from the reference model, push expectations,
    // compare the DUT outputs against popped entries, then advance the model.
    task automatic step();
        int  cnt, eid, gid, ix;
        bit  eg, efull, dl, gv;
        #1;
        cnt   = (mt - mh) & 15;
        efull = (cnt == 8);
        eg    = bus.alloc_req_rs0 && !efull && !nuke;
        if (eg) alloc_q.push_back(mt & 7);
        gv  = 0;
        gid = 0;
        if (!bus.pipe_stall_mm0 && !nuke) begin
            for (int k = 0; k < cnt; k++) begin
                ix = (mh + k) & 7;
                if (!gv && req[ix]) begin
                    gv  = 1;
                    gid = ix;
                end
            end
        end
        if (gv) gnt_q.push_back(gid);
        dl = (cnt != 0) && !ev[mh & 7];

        chk("count", ldq_count, cnt);
        chk("full", ldq_full, efull);
        chk("alloc_gnt", bus.alloc_gnt_rs0, eg);
        if (bus.alloc_gnt_rs0) begin
            if (alloc_q.size() == 0) chk("alloc_unexpected", bus.alloc_gnt_rs0, 0);
            else begin
                eid = alloc_q.pop_front();
                chk("alloc_id", bus.alloc_id_rs0, eid);
                chk("e_alloc", e_alloc, 8'(1) << eid);
            end
        end else begin
            chk("e_alloc_idle", e_alloc, 0);
        end
        alloc_q.delete();
        chk("gnt_valid", bus.pipe_gnt_valid_mm0, gv);
        if (bus.pipe_gnt_valid_mm0) begin
            if (gnt_q.size() == 0) chk("gnt_unexpected", bus.pipe_gnt_valid_mm0, 0);
            else begin
                gid = gnt_q.pop_front();
                chk("gnt_id", bus.pipe_gnt_id_mm0, gid);
                chk("e_pipe_gnt", e_pgnt, 8'(1) << gid);
            end
        end else begin
            chk("e_pipe_gnt_idle", e_pgnt, 0);
        end
        gnt_q.delete();

        @(posedge clk);
        #1;
        if (nuke) begin
            mt = mh;
            ev = '0;
        end else begin
            if (eg) begin
                ev[mt & 7] = 1'b1;
                mt = (mt + 1) & 15;
            end
            if (dl) mh = (mh + 1) & 15;
        end
        @(negedge clk);
    endtask

    initial begin
        bus.alloc_req_rs0  = 1'b0;
        bus.pipe_stall_mm0 = 1'b0;
        ev   = '0;
        req  = '0;
        nuke = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_alloc_gnt", bus.alloc_gnt_rs0, 0);
        chk("rst_e_alloc", e_alloc, 0);
        chk("rst_full", ldq_full, 0);
        chk("rst_count", ldq_count, 0);
        chk("rst_e_pipe_gnt", e_pgnt, 0);
        chk("rst_gnt_valid", bus.pipe_gnt_valid_mm0, 0);
        chk("rst_gnt_id", bus.pipe_gnt_id_mm0, 0);
        reset_n = 1'b1;
        @(negedge clk);

        // Eight back-to-back allocations, then a refused ninth
        bus.alloc_req_rs0 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk("seq_id", bus.alloc_id_rs0, i);
            chk("seq_onehot", e_alloc, 8'(1) << i);
            step();
        end
        #1;
        chk("ninth_gnt", bus.alloc_gnt_rs0, 0);
        chk("ninth_full", ldq_full, 1);
        chk("ninth_count", ldq_count, 8);
        step();

        // Head frees while full: refused this cycle, slot 0 reused next cycle
        ev[0] = 1'b0;
        #1;
        chk("full_free_refuse", bus.alloc_gnt_rs0, 0);
        step();
        #1;
        chk("wrap_gnt", bus.alloc_gnt_rs0, 1);
        chk("wrap_id", bus.alloc_id_rs0, 0);
        step();
        chk("wrap_count", ldq_count, 8);
        bus.alloc_req_rs0 = 1'b0;

        // Retire 1..4 one per cycle so head reaches 5
        ev[4:1] = 4'b0000;
        repeat (4) step();
        chk("head5_count", ldq_count, 4);

        // Oldest-first arbitration from head 5
        req = 8'b1010_0001;
        #1;
        chk("arb_first", bus.pipe_gnt_id_mm0, 5);
        step();
        req = 8'b1000_0001;
        #1;
        chk("arb_second", bus.pipe_gnt_id_mm0, 7);
        step();
        req = 8'b0000_0001;
        #1;
        chk("arb_third", bus.pipe_gnt_id_mm0, 0);
        step();

        // Stall suppresses grant; release grants oldest in the same cycle
        req = 8'b1010_0001;
        bus.pipe_stall_mm0 = 1'b1;
        #1;
        chk("stall_gnt_valid", bus.pipe_gnt_valid_mm0, 0);
        chk("stall_e_gnt", e_pgnt, 0);
        step();
        bus.pipe_stall_mm0 = 1'b0;
        #1;
        chk("unstall_id", bus.pipe_gnt_id_mm0, 5);
        step();
        req = '0;

        // Asynchronous reset mid-operation clears pointers at once
        reset_n = 1'b0;
        #1;
        chk("midrst_count", ldq_count, 0);
        mh = 0;
        mt = 0;
        ev = '0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Build head=2, tail=6, then nuke with an alloc request present
        bus.alloc_req_rs0 = 1'b1;
        repeat (6) step();
        bus.alloc_req_rs0 = 1'b0;
        ev[1:0] = 2'b00;
        repeat (2) step();
        chk("prenuke_count", ldq_count, 4);
        nuke = 1'b1;
        bus.alloc_req_rs0 = 1'b1;
        req = 8'b0000_1000;
        #1;
        chk("nuke_alloc", bus.alloc_gnt_rs0, 0);
        chk("nuke_gnt", bus.pipe_gnt_valid_mm0, 0);
        step();
        nuke = 1'b0;
        req = '0;
        #1;
        chk("postnuke_count", ldq_count, 0);
        chk("postnuke_id", bus.alloc_id_rs0, 2);
        repeat (3) step();
        bus.alloc_req_rs0 = 1'b0;

        // Out-of-order completion waits for the head
        ev[4:3] = 2'b00;
        step();
        chk("ooo_hold1", ldq_count, 3);
        step();
        chk("ooo_hold2", ldq_count, 3);
        ev[2] = 1'b0;
        step();
        chk("drain_a", ldq_count, 2);
        step();
        chk("drain_b", ldq_count, 1);
        step();
        chk("drain_c", ldq_count, 0);

        // Random traffic against the reference model
        for (int n = 0; n < 400; n++) begin
            int cnt;
            logic [7:0] occ;
            cnt = (mt - mh) & 15;
            occ = '0;
            for (int k = 0; k < cnt; k++) occ[(mh + k) & 7] = 1'b1;
            for (int i = 0; i < 8; i++)
                if (occ[i] && ev[i] && ($urandom_range(5) == 0)) ev[i] = 1'b0;
            bus.alloc_req_rs0  = $urandom_range(1);
            bus.pipe_stall_mm0 = ($urandom_range(3) == 0);
            nuke = ($urandom_range(39) == 0);
            req  = 8'($urandom) & ev & occ;
            step();
        end
        bus.alloc_req_rs0 = 1'b0;
        req  = '0;
        nuke = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
